spi_tx_sched: RTL and testbench

Scheduler and command decoder for the SPI slave link. Supplies the 128-bit packet the SPI slave shifts out next, choosing between two packet sources on each next-packet request. Decodes the 32-bit command frames the host sends at the start of each SPI transaction into link control bits. Runs entirely in the system clock domain and synchronises the slave's toggle handshakes internally.

---
 rtl/spi_tx_sched.sv | 195 +++++++++++++++++++
 tb/tb_spi_tx_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sched.sv
// Packet scheduler and command decoder for the SPI slave link.
// Picks the next 128-bit Tx packet from the trace and aux sources, and decodes the host command frames.
module spi_tx_sched #(
  parameter int           SYNC_STAGES = 2,
  parameter logic [127:0] IDLE_PKT    = {16'hA5A5, 112'h0}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         TxGetNext,
  input  logic         PktComplete,
  input  logic [31:0]  RxedFrame,
  output logic [127:0] Tx_packet,
  input  logic [127:0] trace_data,
  input  logic         trace_valid,
  output logic         trace_ready,
  input  logic [127:0] aux_data,
  input  logic         aux_valid,
  output logic         aux_ready,
  output logic         trace_en,
  output logic         aux_en,
  output logic [15:0]  sent_cnt,
  output logic [15:0]  idle_cnt,
  output logic         cmd_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_LOAD} tx_state_t;
  typedef enum logic [1:0] {GR_NONE, GR_TRACE, GR_AUX} grant_t;

  logic [SYNC_STAGES-1:0] get_sync;
  logic [SYNC_STAGES-1:0] pc_sync;
  logic                   get_hist;
  logic                   pc_hist;
  logic                   armed;
  logic                   get_evt;
  logic                   pc_evt;

  tx_state_t state, state_nxt;
  grant_t    grant_q, grant_nxt;
  logic      pending, pending_nxt;
  logic      pend_drop;
  logic      last_grant_trace;
  logic      trace_elig;
  logic      aux_elig;

  logic [31:0] cmd_frame;
  logic        cmd_valid;
  logic        cmd_hdr_ok;
  logic [3:0]  cmd_op;
  logic        cmd_set_en;
  logic        cmd_clear;
  logic        cmd_bad;
  logic        unused_cmd_bits;

  logic load_src;
  logic load_idle;

  // The synchronisers keep sampling through reset so the history flop
  // already holds the real toggle level by the time armed is set.
  always_ff @(posedge clk) begin
    get_sync <= {get_sync[SYNC_STAGES-2:0], TxGetNext};
    pc_sync  <= {pc_sync[SYNC_STAGES-2:0], PktComplete};
    get_hist <= get_sync[SYNC_STAGES-1];
    pc_hist  <= pc_sync[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  assign get_evt = armed & (get_sync[SYNC_STAGES-1] ^ get_hist);
  assign pc_evt  = armed & (pc_sync[SYNC_STAGES-1] ^ pc_hist);

  assign trace_elig = trace_valid & trace_en;
  assign aux_elig   = aux_valid & aux_en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      grant_q <= GR_NONE;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      pending <= pending_nxt;
    end
  end

  // A request arriving while busy is parked in pending; a second one is dropped.
  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    pending_nxt = pending;
    pend_drop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          state_nxt   = ST_ARB;
          pending_nxt = get_evt;
        end else if (get_evt) begin
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        state_nxt = ST_LOAD;
        if (trace_elig && aux_elig)
          grant_nxt = last_grant_trace ? GR_AUX : GR_TRACE;
        else if (trace_elig)
          grant_nxt = GR_TRACE;
        else if (aux_elig)
          grant_nxt = GR_AUX;
        else
          grant_nxt = GR_NONE;
      end
      ST_LOAD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (state != ST_IDLE && get_evt) begin
      if (pending) pend_drop   = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  assign trace_ready = (state == ST_LOAD) && (grant_q == GR_TRACE);
  assign aux_ready   = (state == ST_LOAD) && (grant_q == GR_AUX);
  assign load_src    = (state == ST_LOAD) && (grant_q != GR_NONE);
  assign load_idle   = (state == ST_LOAD) && (grant_q == GR_NONE) && trace_en;

  // The frame is captured on the event cycle and acted on one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_valid <= 1'b0;
      cmd_frame <= 32'h0;
    end else begin
      cmd_valid <= pc_evt;
      if (pc_evt) cmd_frame <= RxedFrame;
    end
  end

  assign cmd_hdr_ok      = (cmd_frame[31:28] == 4'hA);
  assign cmd_op          = cmd_frame[27:24];
  assign cmd_set_en      = cmd_valid && cmd_hdr_ok && (cmd_op == 4'd1);
  assign cmd_clear       = cmd_valid && cmd_hdr_ok && (cmd_op == 4'd2);
  assign cmd_bad         = cmd_valid && (!cmd_hdr_ok || (cmd_op > 4'd2));
  assign unused_cmd_bits = ^cmd_frame[23:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Tx_packet        <= IDLE_PKT;
      last_grant_trace <= 1'b0;
    end else if (state == ST_LOAD) begin
      case (grant_q)
        GR_TRACE: begin
          Tx_packet        <= trace_data;
          last_grant_trace <= 1'b1;
        end
        GR_AUX: begin
          Tx_packet        <= aux_data;
          last_grant_trace <= 1'b0;
        end
        default: Tx_packet <= IDLE_PKT;
      endcase
    end
  end

  // A clear command takes priority over any increment or error landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trace_en <= 1'b0;
      aux_en   <= 1'b0;
      sent_cnt <= 16'h0;
      idle_cnt <= 16'h0;
      cmd_err  <= 1'b0;
    end else begin
      if (cmd_set_en) begin
        trace_en <= cmd_frame[0];
        aux_en   <= cmd_frame[1];
      end
      if (cmd_clear) begin
        sent_cnt <= 16'h0;
        idle_cnt <= 16'h0;
        cmd_err  <= 1'b0;
      end else begin
        if (load_src && sent_cnt != 16'hFFFF)  sent_cnt <= sent_cnt + 16'd1;
        if (load_idle && idle_cnt != 16'hFFFF) idle_cnt <= idle_cnt + 16'd1;
        if (cmd_bad || pend_drop)              cmd_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_sched.sv
// Directed and randomized bench for spi_tx_sched against a packet-level reference model.
module tb_spi_tx_sched;

  localparam logic [127:0] IDLE_PKT = {16'hA5A5, 112'h0};

  logic         clk;
  logic         rst;
  logic         TxGetNext;
  logic         PktComplete;
  logic [31:0]  RxedFrame;
  logic [127:0] Tx_packet;
  logic [127:0] trace_data;
  logic         trace_valid;
  logic         trace_ready;
  logic [127:0] aux_data;
  logic         aux_valid;
  logic         aux_ready;
  logic         trace_en;
  logic         aux_en;
  logic [15:0]  sent_cnt;
  logic [15:0]  idle_cnt;
  logic         cmd_err;

  int total = 0;
  int bad   = 0;

  bit           m_trace_en;
  bit           m_aux_en;
  bit           m_last_trace;
  int           m_sent;
  int           m_idle;
  bit           m_err;
  logic [127:0] m_tx;

  spi_tx_sched #(.SYNC_STAGES(2), .IDLE_PKT(IDLE_PKT)) dut (
    .clk(clk), .rst(rst), .TxGetNext(TxGetNext), .PktComplete(PktComplete),
    .RxedFrame(RxedFrame), .Tx_packet(Tx_packet),
    .trace_data(trace_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .aux_data(aux_data), .aux_valid(aux_valid), .aux_ready(aux_ready),
    .trace_en(trace_en), .aux_en(aux_en), .sent_cnt(sent_cnt),
    .idle_cnt(idle_cnt), .cmd_err(cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_trace_en = 0; m_aux_en = 0; m_last_trace = 0;
    m_sent = 0; m_idle = 0; m_err = 0; m_tx = IDLE_PKT;
  endtask

  // 0 = idle packet, 1 = trace, 2 = aux; round robin only matters when both are eligible
  function automatic int pick_grant(bit te, bit ae);
    if (te && ae) return m_last_trace ? 2 : 1;
    if (te) return 1;
    if (ae) return 2;
    return 0;
  endfunction

  task automatic apply_grant(input int g, input logic [127:0] data);
    m_tx = data;
    if (g == 1) m_last_trace = 1;
    if (g == 2) m_last_trace = 0;
    if (g != 0 && m_sent < 65535) m_sent++;
    if (g == 0 && m_trace_en && m_idle < 65535) m_idle++;
  endtask

  task automatic check_status(input string tag);
    checkOutput({tag, "_trace_en"}, 128'(trace_en), 128'(m_trace_en));
    checkOutput({tag, "_aux_en"},   128'(aux_en),   128'(m_aux_en));
    checkOutput({tag, "_sent"},     128'(sent_cnt), 128'(m_sent));
    checkOutput({tag, "_idle"},     128'(idle_cnt), 128'(m_idle));
    checkOutput({tag, "_err"},      128'(cmd_err),  128'(m_err));
  endtask

  task automatic applyStimulus();
    TxGetNext = ~TxGetNext;
  endtask

  task automatic send_cmd(input logic [31:0] frame);
    logic [3:0] hdr;
    logic [3:0] op;
    hdr = frame[31:28];
    op  = frame[27:24];
    RxedFrame   = frame;
    PktComplete = ~PktComplete;
    repeat (6) @(negedge clk);
    if (hdr != 4'hA) m_err = 1;
    else if (op == 4'd1) begin m_trace_en = frame[0]; m_aux_en = frame[1]; end
    else if (op == 4'd2) begin m_sent = 0; m_idle = 0; m_err = 0; end
    else if (op != 4'd0) m_err = 1;
  endtask

  task automatic do_get_next(input string tag);
    int g;
    int tr_cnt;
    int ar_cnt;
    logic [127:0] exp_tx;
    g = pick_grant(trace_valid && m_trace_en, aux_valid && m_aux_en);
    exp_tx = (g == 1) ? trace_data : (g == 2) ? aux_data : IDLE_PKT;
    tr_cnt = 0;
    ar_cnt = 0;
    applyStimulus();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      tr_cnt += int'(trace_ready);
      ar_cnt += int'(aux_ready);
      if (i == 4) checkOutput({tag, "_tx_hold"}, Tx_packet, m_tx);
    end
    checkOutput({tag, "_tx"}, Tx_packet, exp_tx);
    checkOutput({tag, "_trdy"}, 128'(tr_cnt), 128'(g == 1));
    checkOutput({tag, "_ardy"}, 128'(ar_cnt), 128'(g == 2));
    apply_grant(g, exp_tx);
    if (g == 1) trace_data = rnd128();
    if (g == 2) aux_data = rnd128();
  endtask

  // Extra toggles land in ARB (and LOAD when twice is set) of the first request.
  task automatic pending_test(input string tag, input bit twice);
    int g1;
    int g2;
    int tr_cnt;
    int ar_cnt;
    logic [127:0] d1;
    logic [127:0] d2;
    g1 = pick_grant(1, 1);
    d1 = (g1 == 1) ? trace_data : aux_data;
    d2 = (g1 == 1) ? aux_data : trace_data;
    g2 = (g1 == 1) ? 2 : 1;
    tr_cnt = 0;
    ar_cnt = 0;
    applyStimulus();
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    if (twice) applyStimulus();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      tr_cnt += int'(trace_ready);
      ar_cnt += int'(aux_ready);
    end
    apply_grant(g1, d1);
    apply_grant(g2, d2);
    if (twice) m_err = 1;
    checkOutput({tag, "_tx"}, Tx_packet, d2);
    checkOutput({tag, "_trdy"}, 128'(tr_cnt), 128'd1);
    checkOutput({tag, "_ardy"}, 128'(ar_cnt), 128'd1);
    check_status(tag);
    trace_data = rnd128();
    aux_data   = rnd128();
  endtask

  initial begin
    int pulses;
    int tx_bad;
    logic [31:0] f;
    rst = 1'b0;
    TxGetNext = 1'b1;
    PktComplete = 1'b1;
    RxedFrame = 32'h0;
    trace_valid = 1'b0;
    aux_valid = 1'b0;
    trace_data = rnd128();
    aux_data = rnd128();
    model_reset();
    repeat (6) @(negedge clk);
    rst = 1'b1;

    pulses = 0;
    tx_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      pulses += int'(trace_ready) + int'(aux_ready);
      if (Tx_packet !== IDLE_PKT) tx_bad++;
    end
    checkOutput("por_ready", 128'(pulses), 128'd0);
    checkOutput("por_tx_changes", 128'(tx_bad), 128'd0);
    checkOutput("por_tx", Tx_packet, IDLE_PKT);
    check_status("por");

    send_cmd(32'hA100_0003);
    check_status("en_both");
    trace_valid = 1'b1;
    aux_valid = 1'b1;
    do_get_next("rr1");
    do_get_next("rr2");
    do_get_next("rr3");
    do_get_next("rr4");
    check_status("rr");

    send_cmd(32'hA100_0001);
    trace_valid = 1'b0;
    aux_valid = 1'b0;
    do_get_next("idle1");
    do_get_next("idle2");
    do_get_next("idle3");
    check_status("idle");

    send_cmd(32'h5100_0001);
    check_status("bad_hdr");
    send_cmd(32'hA200_0000);
    check_status("clear");

    send_cmd(32'hA100_0003);
    trace_valid = 1'b1;
    aux_valid = 1'b1;
    pending_test("pend1", 1'b0);
    pending_test("pend2", 1'b1);
    send_cmd(32'hA200_0000);
    check_status("clear2");

    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0: send_cmd(32'hA100_0000 | 32'($urandom_range(0, 3)));
        1: begin
          f = $urandom;
          if ($urandom_range(0, 1) == 1) f[31:28] = 4'hA;
          f[27:24] = 4'($urandom_range(0, 4));
          send_cmd(f);
        end
        default: ;
      endcase
      trace_valid = 1'($urandom_range(0, 1));
      aux_valid   = 1'($urandom_range(0, 1));
      do_get_next("rnd");
      check_status("rnd");
    end

    send_cmd(32'hA100_0003);
    trace_valid = 1'b1;
    aux_valid = 1'b1;
    applyStimulus();
    repeat (4) @(negedge clk);
    checkOutput("rstload_pre", 128'(trace_ready | aux_ready), 128'd1);
    rst = 1'b0;
    #1;
    model_reset();
    checkOutput("rstload_trdy", 128'(trace_ready), 128'd0);
    checkOutput("rstload_ardy", 128'(aux_ready), 128'd0);
    checkOutput("rstload_tx", Tx_packet, IDLE_PKT);
    check_status("rstload");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    do_get_next("post_rst");
    check_status("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
